laser_pt_feeder: RTL and testbench
==================================

LASER_PT_FEEDER -- requirements
Module: laser_pt_feeder

Interface
REQ-001 Parameter NUM_PTS, default 40: points per frame, one LASER frame.
REQ-002 Parameter CNT_W, default 8: width of FRAME_CNT.
REQ-003 CLK  input  1: single clock; all state on its rising edge.
REQ-004 RST_N  input  1: reset, asynchronous assert, active-low.
REQ-005 IN_VALID  input  1: upstream point valid.
REQ-006 IN_READY  output  1: feeder accepts point this cycle.
REQ-007 IN_X, IN_Y  input  4 each: point coordinates.
REQ-008 CORE_RST  output  1: drives LASER RST (active-high, synchronous in core).
REQ-009 CORE_X, CORE_Y  output  4 each: drive LASER X/Y.
REQ-010 CORE_DONE  input  1: LASER DONE (1-cycle pulse).
REQ-011 BUSY  output  1: frame streaming or awaiting CORE_DONE.
REQ-012 FRAME_CNT  output  CNT_W: completed frames, wraps modulo 2^CNT_W.

Function
REQ-013 Transfer occurs iff IN_VALID && IN_READY at a rising edge; the point is written to the write bank at index wr_idx, and wr_idx increments.
REQ-014 FSM states: COLLECT, KICK, STREAM, WAIT_DONE; all outputs are registered.
REQ-015 COLLECT: CORE_RST=1, IN_READY=1 while wr_idx<NUM_PTS; the NUM_PTS-th transfer moves to KICK next cycle.
REQ-016 KICK (1 cycle): CORE_RST=1; bank point 0 loaded into CORE_X/CORE_Y.
REQ-017 STREAM: CORE_RST=0 from its first cycle; in the k-th STREAM cycle (k=0..NUM_PTS-1), CORE_X/CORE_Y equal point k in arrival order, with no gaps.
REQ-018 After point NUM_PTS-1, go to WAIT_DONE; CORE_X/CORE_Y hold the last value.
REQ-019 WAIT_DONE: CORE_RST=0; on CORE_DONE=1, FRAME_CNT increments, and the FSM goes to COLLECT (or directly to KICK per REQ-025).
REQ-020 BUSY=1 in STREAM and WAIT_DONE, else 0.
REQ-021 CORE_DONE outside WAIT_DONE is ignored.
REQ-022 IN_VALID with IN_READY=0 loses no data; upstream holds.

Reset
REQ-023 On RST_N=0, asynchronously: state=COLLECT, wr_idx=0, CORE_RST=1, CORE_X=CORE_Y=0, IN_READY=0, BUSY=0, FRAME_CNT=0, bank pointers=0; bank contents are not reset.
REQ-024 Reset mid-frame discards all partial and streamed data; IN_READY rises the first cycle after RST_N deasserts.

Configuration
REQ-025 Macro LASER_FEED_PINGPONG_EN present: two banks; collecting into the write bank continues during KICK/STREAM/WAIT_DONE. When CORE_DONE arrives and the write bank is full, banks swap and the FSM goes straight to KICK. A simultaneous final transfer and CORE_DONE counts as full. IN_READY=0 only while the write bank is full.
REQ-026 Macro absent: one bank; IN_READY=1 only in COLLECT with wr_idx<NUM_PTS; after CORE_DONE, return to COLLECT with wr_idx=0.

Verification
REQ-027 Reset, then 40 back-to-back points (x=i%16, y=(i*3)%16) -> KICK one cycle after the 40th, CORE_RST falls, CORE_X/Y show points 0..39 in 40 consecutive cycles.
REQ-028 Random IN_VALID gaps (50% duty) over 40 points -> identical CORE stream order; no duplicates, no loss.
REQ-029 CORE_DONE pulse 500 cycles after stream end -> FRAME_CNT 0->1, BUSY falls next cycle; CORE_DONE pulse in COLLECT -> FRAME_CNT unchanged.
REQ-030 RST_N low for 1 cycle during STREAM at point 17 -> CORE_RST=1 immediately, FRAME_CNT=0, next 40 points streamed from index 0.
REQ-031 PINGPONG_EN: frame B fully loaded during frame A's WAIT_DONE -> CORE_DONE is followed by KICK next cycle, IN_READY=1 again, frame B streams intact.
REQ-032 Without PINGPONG_EN: IN_VALID held high during STREAM -> IN_READY=0 until CORE_DONE, zero transfers.

Source files
------------

// File: rtl/laser_pt_feeder.sv
// laser_pt_feeder: buffers NUM_PTS-point frames and streams them into a LASER core
// Ports: CLK; RST_N async active-low reset; IN_VALID/IN_READY/IN_X/IN_Y upstream point handshake;
//   CORE_RST/CORE_X/CORE_Y drive the core, CORE_DONE is its frame-complete pulse;
//   BUSY marks streaming or awaiting CORE_DONE; FRAME_CNT counts completed frames (wraps).
// Define LASER_FEED_PINGPONG_EN for two banks so the next frame loads while the current one plays.
module laser_pt_feeder #(
  parameter int NUM_PTS = 40,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       IN_X,
  input  logic [3:0]       IN_Y,
  output logic             CORE_RST,
  output logic [3:0]       CORE_X,
  output logic [3:0]       CORE_Y,
  input  logic             CORE_DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] FRAME_CNT
);
`ifdef LASER_FEED_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int IW = $clog2(NUM_PTS + 1);
  localparam int AW = $clog2(NB * NUM_PTS + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_PTS - 1);
  localparam logic [IW-1:0] FULL = IW'(NUM_PTS);
  typedef enum logic [1:0] {COLLECT, KICK, STREAM, WAIT_DONE} state_t;
  state_t state;
  logic [7:0] mem [NB*NUM_PTS];
  logic [IW-1:0] wr_idx, rd_idx, wr_idx_nxt, rd_nxt;
  logic wr_bank, rd_bank, xfer, last_wr, fin, clr, kick_now, ready_nxt;
  logic [AW-1:0] wa, ra;
  always_comb begin
    xfer = IN_VALID && IN_READY;
    last_wr = xfer && wr_idx == LAST;
    fin = state == WAIT_DONE && CORE_DONE;
`ifdef LASER_FEED_PINGPONG_EN
    // a bank filling on this very edge counts as full, so a coincident CORE_DONE swaps straight to KICK
    clr = (wr_idx == FULL || last_wr) && (state == COLLECT || fin);
    kick_now = clr && fin;
    rd_bank = ~wr_bank;
`else
    clr = fin;
    kick_now = 1'b0;
    rd_bank = 1'b0;
`endif
    wr_idx_nxt = clr ? '0 : wr_idx + IW'(xfer);
`ifdef LASER_FEED_PINGPONG_EN
    ready_nxt = wr_idx_nxt != FULL;
`else
    ready_nxt = (state == COLLECT && !last_wr) || fin;
`endif
    // KICK preloads point 0 so STREAM shows point k in its k-th cycle
    rd_nxt = state == KICK ? '0 : rd_idx + IW'(1);
    wa = AW'(wr_bank ? NUM_PTS : 0) + AW'(wr_idx);
    ra = AW'(rd_bank ? NUM_PTS : 0) + AW'(rd_nxt);
  end
  always_ff @(posedge CLK)
    if (xfer) mem[wa] <= {IN_X, IN_Y};
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= COLLECT;
      wr_idx <= '0;
      rd_idx <= '0;
      wr_bank <= 1'b0;
      CORE_RST <= 1'b1;
      CORE_X <= '0;
      CORE_Y <= '0;
      IN_READY <= 1'b0;
      BUSY <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      wr_idx <= wr_idx_nxt;
      IN_READY <= ready_nxt;
`ifdef LASER_FEED_PINGPONG_EN
      wr_bank <= wr_bank ^ clr;
`endif
      case (state)
        COLLECT: if (last_wr) state <= KICK;
        KICK: begin
          state <= STREAM;
          CORE_RST <= 1'b0;
          BUSY <= 1'b1;
          rd_idx <= rd_nxt;
          {CORE_X, CORE_Y} <= mem[ra];
        end
        STREAM: if (rd_idx == LAST) state <= WAIT_DONE;
          else begin
            rd_idx <= rd_nxt;
            {CORE_X, CORE_Y} <= mem[ra];
          end
        WAIT_DONE: if (CORE_DONE) begin
          FRAME_CNT <= FRAME_CNT + CNT_W'(1);
          BUSY <= 1'b0;
          CORE_RST <= 1'b1;
          state <= kick_now ? KICK : COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
endmodule

// File: tb/tb_laser_pt_feeder.sv
// tb_laser_pt_feeder: self-checking bench for laser_pt_feeder
module tb_laser_pt_feeder;
  localparam int N = 40;
`ifdef LASER_FEED_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  typedef struct {
    logic v;
    logic [3:0] x;
    logic [3:0] y;
    logic rdy;
    logic rst;
    logic busy;
    logic cxy;
    logic [3:0] ex;
    logic [3:0] ey;
  } vec_t;
  logic CLK = 1'b0, RST_N = 1'b0, IN_VALID = 1'b0, CORE_DONE = 1'b0;
  logic [3:0] IN_X = '0, IN_Y = '0;
  logic IN_READY, CORE_RST, BUSY;
  logic [3:0] CORE_X, CORE_Y;
  logic [7:0] FRAME_CNT;
  int errors = 0, checks = 0, exp_cnt = 0, xfers = 0;
  logic [7:0] exp_q [$];
  vec_t tbl [82];
  laser_pt_feeder #(.NUM_PTS(N), .CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_X(IN_X), .IN_Y(IN_Y), .CORE_RST(CORE_RST), .CORE_X(CORE_X), .CORE_Y(CORE_Y),
    .CORE_DONE(CORE_DONE), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
  );
  always #5 CLK = ~CLK;
  initial begin
    #1000000;
    $display("FAIL watchdog: got no summary by time limit, required finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask
  task automatic feed_random();
    int n = 0;
    int t = 0;
    exp_q.delete();
    while (n < N && t < 1000) begin
      chk("feed_ready", int'(IN_READY), 1);
      IN_VALID = 1'($urandom_range(0, 1));
      IN_X = 4'($urandom);
      IN_Y = 4'($urandom);
      if (IN_VALID) begin
        exp_q.push_back({IN_X, IN_Y});
        n++;
      end
      @(negedge CLK);
      t++;
    end
    IN_VALID = 1'b0;
    chk("feed_count", n, N);
  endtask
  task automatic check_stream(input string name, input logic hold);
    int t = 0;
    IN_VALID = hold;
    IN_X = 4'hA;
    IN_Y = 4'h5;
    while (CORE_RST && t < 200) begin
      xfers += int'(IN_VALID && IN_READY);
      @(negedge CLK);
      t++;
    end
    chk({name, "_started"}, int'(CORE_RST), 0);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_pt%0d", name, k), int'({CORE_X, CORE_Y}), int'(exp_q[k]));
      chk($sformatf("%s_busy%0d", name, k), int'(BUSY), 1);
      xfers += int'(IN_VALID && IN_READY);
      @(negedge CLK);
    end
    repeat (5) begin
      chk({name, "_wait_ready"}, int'(IN_READY), int'(PP));
      chk({name, "_hold_last"}, int'({CORE_X, CORE_Y}), int'(exp_q[N-1]));
      xfers += int'(IN_VALID && IN_READY);
      @(negedge CLK);
    end
  endtask
  task automatic pulse_done(input string name, input logic in_wait);
    CORE_DONE = 1'b1;
    @(negedge CLK);
    CORE_DONE = 1'b0;
    IN_VALID = 1'b0;
    if (in_wait) exp_cnt = (exp_cnt + 1) % 256;
    chk({name, "_cnt"}, int'(FRAME_CNT), exp_cnt);
    chk({name, "_busy"}, int'(BUSY), 0);
    chk({name, "_ready"}, int'(IN_READY), 1);
    chk({name, "_core_rst"}, int'(CORE_RST), 1);
  endtask
  initial begin
    int t;
    for (int i = 0; i < 82; i++) begin
      tbl[i].v = i < N;
      tbl[i].x = 4'(i % 16);
      tbl[i].y = 4'((i * 3) % 16);
      tbl[i].rdy = i < N ? 1'b1 : PP;
      tbl[i].rst = i <= N;
      tbl[i].busy = i > N;
      tbl[i].cxy = i > N;
      tbl[i].ex = 4'((i > 80 ? 39 : (i > N ? i - 41 : 0)) % 16);
      tbl[i].ey = 4'(((i > 80 ? 39 : (i > N ? i - 41 : 0)) * 3) % 16);
    end
    repeat (3) @(negedge CLK);
    chk("reset_core_rst", int'(CORE_RST), 1);
    chk("reset_ready", int'(IN_READY), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_cnt", int'(FRAME_CNT), 0);
    chk("reset_xy", int'({CORE_X, CORE_Y}), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    for (int r = 0; r < 82; r++) begin
      chk($sformatf("tbl%0d_ready", r), int'(IN_READY), int'(tbl[r].rdy));
      chk($sformatf("tbl%0d_core_rst", r), int'(CORE_RST), int'(tbl[r].rst));
      chk($sformatf("tbl%0d_busy", r), int'(BUSY), int'(tbl[r].busy));
      if (tbl[r].cxy) begin
        chk($sformatf("tbl%0d_x", r), int'(CORE_X), int'(tbl[r].ex));
        chk($sformatf("tbl%0d_y", r), int'(CORE_Y), int'(tbl[r].ey));
      end
      IN_VALID = tbl[r].v;
      IN_X = tbl[r].x;
      IN_Y = tbl[r].y;
      @(negedge CLK);
    end
    repeat (498) @(negedge CLK);
    chk("wait500_busy", int'(BUSY), 1);
    chk("wait500_cnt", int'(FRAME_CNT), 0);
    pulse_done("done_after_500", 1'b1);
    pulse_done("done_in_collect", 1'b0);
    feed_random();
    check_stream("rand", !PP);
    pulse_done("rand_done", 1'b1);
    chk("hold_xfers", xfers, 0);
    feed_random();
    t = 0;
    while (CORE_RST && t < 200) begin
      @(negedge CLK);
      t++;
    end
    repeat (17) @(negedge CLK);
    chk("pre_reset_pt17", int'({CORE_X, CORE_Y}), int'(exp_q[17]));
    RST_N = 1'b0;
    #1;
    exp_cnt = 0;
    chk("midreset_core_rst", int'(CORE_RST), 1);
    chk("midreset_cnt", int'(FRAME_CNT), 0);
    chk("midreset_busy", int'(BUSY), 0);
    chk("midreset_ready", int'(IN_READY), 0);
    chk("midreset_xy", int'({CORE_X, CORE_Y}), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_reset_ready", int'(IN_READY), 1);
    feed_random();
    check_stream("after_reset", 1'b0);
    pulse_done("after_reset_done", 1'b1);
`ifdef LASER_FEED_PINGPONG_EN
    feed_random();
    check_stream("pp_a", 1'b0);
    feed_random();
    chk("pp_b_full_ready", int'(IN_READY), 0);
    pulse_done("pp_a_done", 1'b1);
    check_stream("pp_b", 1'b0);
    pulse_done("pp_b_done", 1'b1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
